// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard and sequencing controller for the 5-stage RV32I pipeline.
// Produces the stall/flush enables for the F/D, D/E, E/M and M/W pipeline
// registers and the forwarding selects of the execute-stage operand muxes.
// It also owns the data-memory request/acknowledge handshake of the memory
// stage: wait states freeze the whole pipeline, and an access that is not
// acknowledged within DMEM_TIMEOUT wait cycles traps into a sticky error
// state that only reset leaves.
//
// Parameters
//   DMEM_TIMEOUT  max consecutive wait cycles in WAIT before the trap (2..255)
//
// Ports
//   i_clk, i_rstn               clock, asynchronous active-low reset
//   i_rs1_addrD, i_rs2_addrD    decode-stage source registers
//   i_rs1_addrE, i_rs2_addrE    execute-stage source registers
//   i_rd_addrE/M/W              destination registers of E, M, W
//   i_result_srcE               result select of E (01 = load)
//   i_reg_wr_enM, i_reg_wr_enW  register write enables of M and W
//   i_pc_srcE                   branch/jump taken in E
//   i_mem_reqM                  M instruction is a load or store
//   i_dmem_ack                  data memory completes the access this cycle
//   o_dmem_req                  access request to data memory
//   o_fwd_aE, o_fwd_bE          operand forward select (10 M, 01 W, 00 RF)
//   o_stallF/D/E/M              hold the corresponding pipeline register
//   o_flushD/E/W                load a bubble into the D/E/W register
//   o_bus_err                   sticky memory timeout flag
//   o_busy                      handshake FSM is in WAIT
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [4:0] i_rs1_addrD,
    input  logic [4:0] i_rs2_addrD,
    input  logic [4:0] i_rs1_addrE,
    input  logic [4:0] i_rs2_addrE,
    input  logic [4:0] i_rd_addrE,
    input  logic [4:0] i_rd_addrM,
    input  logic [4:0] i_rd_addrW,
    input  logic [1:0] i_result_srcE,
    input  logic       i_reg_wr_enM,
    input  logic       i_reg_wr_enW,
    input  logic       i_pc_srcE,
    input  logic       i_mem_reqM,
    input  logic       i_dmem_ack,
    output logic       o_dmem_req,
    output logic [1:0] o_fwd_aE,
    output logic [1:0] o_fwd_bE,
    output logic       o_stallF,
    output logic       o_stallD,
    output logic       o_stallE,
    output logic       o_stallM,
    output logic       o_flushD,
    output logic       o_flushE,
    output logic       o_flushW,
    output logic       o_bus_err,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } state_t;

    localparam logic [1:0] RES_LOAD    = 2'b01;
    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [7:0] TIMEOUT_CNT = 8'(DMEM_TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       lw_stall;
    logic       mem_stall;

    // ------------------------------------------------------------------
    // Forwarding. x0 is never forwarded; the younger producer (M) wins
    // over the older one (W) so the most recent value reaches execute.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if ((rs != 5'd0) && (rs == rd_m) && wr_m) begin
            sel = FWD_M;
        end else if ((rs != 5'd0) && (rs == rd_w) && wr_w) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    assign o_fwd_aE = fwd_sel(i_rs1_addrE, i_rd_addrM, i_reg_wr_enM,
                              i_rd_addrW, i_reg_wr_enW);
    assign o_fwd_bE = fwd_sel(i_rs2_addrE, i_rd_addrM, i_reg_wr_enM,
                              i_rd_addrW, i_reg_wr_enW);

    // A load in E cannot forward to the instruction in D until it has
    // reached W, so D is held one cycle and a bubble goes into E.
    assign lw_stall = (i_result_srcE == RES_LOAD) && (i_rd_addrE != 5'd0) &&
                      ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

    // ------------------------------------------------------------------
    // Data-memory handshake FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Data-memory handshake FSM: next state and request.
    // wait_cnt numbers the wait cycles of the current access; the IDLE
    // cycle that raised the request already counts as wait cycle 1 when
    // it is not acknowledged, so the trap fires after DMEM_TIMEOUT+1
    // request cycles without ack.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        o_dmem_req    = 1'b0;
        case (state)
            IDLE: begin
                o_dmem_req = i_mem_reqM;
                if (i_mem_reqM && !i_dmem_ack) begin
                    state_next    = WAIT;
                    wait_cnt_next = 8'd1;
                end
            end
            WAIT: begin
                o_dmem_req = 1'b1;
                if (i_dmem_ack) begin
                    state_next    = IDLE;
                    wait_cnt_next = 8'd0;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    state_next = ERR;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            ERR: begin
                // Terminal until reset; request stays low.
                state_next = ERR;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    // o_dmem_req is already 0 in ERR, so mem_stall only exists in IDLE/WAIT.
    assign mem_stall = o_dmem_req && !i_dmem_ack;
    assign o_bus_err = (state == ERR);
    assign o_busy    = (state == WAIT);

    // ------------------------------------------------------------------
    // Stall / flush generation. A memory wait freezes every stage and
    // feeds bubbles into W; load-use and taken-branch hazards are held
    // off until the wait releases, then re-evaluated from live inputs.
    // ------------------------------------------------------------------
    always_comb begin
        o_stallF = 1'b0;
        o_stallD = 1'b0;
        o_stallE = 1'b0;
        o_stallM = 1'b0;
        o_flushD = 1'b0;
        o_flushE = 1'b0;
        o_flushW = 1'b0;
        if (state == ERR) begin
            o_stallF = 1'b1;
            o_stallD = 1'b1;
            o_stallE = 1'b1;
            o_stallM = 1'b1;
        end else if (mem_stall) begin
            o_stallF = 1'b1;
            o_stallD = 1'b1;
            o_stallE = 1'b1;
            o_stallM = 1'b1;
            o_flushW = 1'b1;
        end else begin
            o_stallF = lw_stall;
            o_stallD = lw_stall;
            o_flushD = i_pc_srcE;
            o_flushE = lw_stall | i_pc_srcE;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It generates the stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers and the forwarding selects for the execute-stage operand muxes. It also runs the data-memory request/acknowledge handshake for the memory stage, freezing the pipeline on wait states and trapping on a memory timeout.

## Interface
- DMEM_TIMEOUT, 16: max consecutive wait cycles tolerated in WAIT before the error trap (range 2..255).
- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low; clock i_clk.
- i_rs1_addrD / i_rs2_addrD  in  5 each  decode-stage source registers.
- i_rs1_addrE / i_rs2_addrE  in  5 each  execute-stage source registers.
- i_rd_addrE / i_rd_addrM / i_rd_addrW  in  5 each  destination registers of E, M, W.
- i_result_srcE  in  2  result select of E instruction (00 alu, 01 load, 10 PC+4, 11 PC target).
- i_reg_wr_enM / i_reg_wr_enW  in  1 each  register write enables of M and W.
- i_pc_srcE  in  1  branch/jump taken in E.
- i_mem_reqM  in  1  M instruction is a load or store.
- i_dmem_ack  in  1  data memory completes the current access this cycle.
- o_dmem_req  out  1  access request to data memory.
- o_fwd_aE / o_fwd_bE  out  2 each  operand forward select (00 regfile, 10 M alu result, 01 W result).
- o_stallF / o_stallD / o_stallE / o_stallM  out  1 each  hold the corresponding pipeline register.
- o_flushD / o_flushE / o_flushW  out  1 each  load a bubble (all controls 0) into D/E/W register.
- o_bus_err  out  1  sticky memory timeout flag.
- o_busy  out  1  FSM in WAIT.

## Operation
- Forwarding (combinational), per operand, e.g. A: 10 if rs1E≠0 & rs1E==rdM & reg_wr_enM; else 01 if rs1E≠0 & rs1E==rdW & reg_wr_enW; else 00. M has priority over W.
- lw_stall = (i_result_srcE==01) & rdE≠0 & (rdE==rs1D | rdE==rs2D).
- FSM states: IDLE, WAIT, ERR; 8-bit wait counter.
- IDLE: o_dmem_req = i_mem_reqM. req & ack → stay IDLE (zero-wait access). req & !ack → WAIT, counter←1.
- WAIT: o_dmem_req=1. ack → IDLE, counter←0. !ack & counter==DMEM_TIMEOUT → ERR. Otherwise counter+1.
- ERR: o_dmem_req=0, o_bus_err=1. All stalls=1; all flushes=0. ERR exits only on reset.
- mem_stall = o_dmem_req & !i_dmem_ack (IDLE/WAIT only).
- mem_stall: o_stallF/D/E/M=1, o_flushW=1, o_flushD=o_flushE=0. mem_stall overrides lw_stall and i_pc_srcE; both are re-evaluated once the stall releases.
- Otherwise: o_stallF=o_stallD=lw_stall; o_flushD=i_pc_srcE; o_flushE=lw_stall|i_pc_srcE; o_stallE=o_stallM=o_flushW=0.
- lw_stall and i_pc_srcE cannot both come from the same E instruction. If both are asserted, flushE=1 and stallF/D=1; no extra priority is defined.

## Timing
- Reset (async): state IDLE, counter 0, o_bus_err 0, o_busy 0. All other outputs are combinational from inputs and state, so during reset they follow the IDLE equations.
- Reset asserted mid-WAIT or in ERR: returns to IDLE immediately; o_dmem_req drops unless i_mem_reqM.
- Forward, stall and flush outputs have zero-cycle latency from inputs; the state register updates on the i_clk rising edge.
- An access with N wait cycles (ack on cycle N+1 of the request) stalls the pipeline exactly N cycles. The counter is 8-bit, so there is no wrap: the FSM reaches ERR after DMEM_TIMEOUT+1 request cycles without ack.
- The ack is sampled only while o_dmem_req=1; an ack while IDLE with no request is ignored.

## Test plan
- Back-to-back add x5 then add x6,x5,x5 (rdM=5, wr_enM=1, rs1E=rs2E=5) → o_fwd_aE=o_fwd_bE=10. Same with rdM=0 → 00.
- Load in E, rdE=7, rs2D=7 → one cycle of stallF=stallD=1 and flushE=1; next cycle all 0 and o_fwd_bE=01 once the load reaches W.
- i_pc_srcE=1 with no memory activity → flushD=flushE=1 for one cycle, stalls 0.
- i_mem_reqM=1, ack after 3 wait cycles → o_busy 1 for 3 cycles, stallF..M=1 and flushW=1 for exactly 3 cycles, then IDLE.
- i_mem_reqM=1, no ack, DMEM_TIMEOUT=16 → ERR after 17 request cycles: o_bus_err=1, o_dmem_req=0, all stalls 1. Pulse i_rstn low mid-ERR → IDLE, o_bus_err 0.
- Branch taken in E during a memory wait → no flush while stalled; flushD/E assert in the first cycle after ack.
